// File: rtl/accfxp_blk_obf.sv
// Block accumulator: sums `count` signed samples into a wider accumulator and
// emits each block sum on a valid/ready register. The key selects saturate (1) or wrap (0).
module accfxp_blk_obf #(
   parameter int unsigned width     = 16,
   parameter int unsigned acc_width = 24,
   parameter int unsigned count     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [width-1:0]     in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [acc_width-1:0] out_data,
   output logic                 out_ovf,
   input  logic                 out_ready,
   input  logic [0:0]           working_locking_key
);

   localparam int unsigned CNT_W = (count > 1) ? $clog2(count) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(count - 1);
   localparam logic [acc_width-1:0] ACC_MAX  = {1'b0, {(acc_width-1){1'b1}}};
   localparam logic [acc_width-1:0] ACC_MIN  = {1'b1, {(acc_width-1){1'b0}}};

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t               state_r, state_nx;
   logic [acc_width-1:0] acc_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 ovf_r;

   logic                 accept;
   logic                 last;
   logic [acc_width:0]   in_ext;
   logic [acc_width:0]   exact;
   logic                 step_ovf;
   logic [acc_width-1:0] result;

   assign in_ready = (state_r == ACCUM) && !rst;
   assign accept   = in_valid && in_ready;
   assign last     = (cnt_r == CNT_LAST);

   // One guard bit above the accumulator is enough to detect any single-step overflow.
   assign in_ext   = {{(acc_width+1-width){in_data[width-1]}}, in_data};
   assign exact    = {acc_r[acc_width-1], acc_r} + in_ext;
   assign step_ovf = exact[acc_width] != exact[acc_width-1];

   always_comb begin
      result = exact[acc_width-1:0];
      if (working_locking_key[0] && step_ovf)
         result = exact[acc_width] ? ACC_MIN : ACC_MAX;
   end

   always_comb begin
      state_nx = state_r;
      case (state_r)
         ACCUM:   if (accept && last) state_nx = HOLD;
         HOLD:    if (out_ready)      state_nx = ACCUM;
         default: state_nx = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ACCUM;
         acc_r     <= '0;
         cnt_r     <= '0;
         ovf_r     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else begin
         state_r <= state_nx;
         if (accept) begin
            if (last) begin
               out_data  <= result;
               out_ovf   <= ovf_r | step_ovf;
               out_valid <= 1'b1;
               acc_r     <= '0;
               cnt_r     <= '0;
               ovf_r     <= 1'b0;
            end else begin
               acc_r <= result;
               cnt_r <= cnt_r + 1'b1;
               ovf_r <= ovf_r | step_ovf;
            end
         end
         if (state_r == HOLD && out_ready)
            out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_accfxp_blk_obf.sv
// Directed self-checking bench for accfxp_blk_obf (width 16, acc_width 18, count 8).
module tb_accfxp_blk_obf;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [17:0] out_data;
   logic        out_ovf;
   logic        out_ready;
   logic [0:0]  key;

   int n_cmp = 0;
   int n_err = 0;

   accfxp_blk_obf #(.width(16), .acc_width(18), .count(8)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .in_valid            (in_valid),
      .in_data             (in_data),
      .in_ready            (in_ready),
      .out_valid           (out_valid),
      .out_data            (out_data),
      .out_ovf             (out_ovf),
      .out_ready           (out_ready),
      .working_locking_key (key)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v);
      in_valid = 1'b1;
      in_data  = v;
      step();
      in_valid = 1'b0;
   endtask

   task automatic push_n(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) push(v);
   endtask

   task automatic chk_out(input string tag, input logic [31:0] data, input logic ovf);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_data"}, {14'd0, out_data}, data);
      chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      step();
      chk({tag, "_hs_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_hs_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; key = 1'b1;
      #12;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {14'd0, out_data}, 32'd0);
      chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
      step();

      // Basic sum
      push(16'd100); push(-16'sd30); push(16'd7); push_n(16'd0, 4);
      chk("basic_pre_valid", {31'd0, out_valid}, 32'd0);
      push(16'd0);
      chk_out("basic", 32'd77, 1'b0);
      handshake("basic");

      // Positive saturation then flag clears
      push_n(16'd32767, 8);
      chk_out("sat", 32'd131071, 1'b1);
      handshake("sat");
      push_n(16'd1, 8);
      chk_out("ones", 32'd8, 1'b0);
      handshake("ones");

      // Wrong key wraps, right key clamps negative
      key = 1'b0;
      push_n(16'd32767, 8);
      chk_out("wrap", 32'h3FFF8, 1'b1);
      handshake("wrap");
      key = 1'b1;
      push_n(16'h8000, 8);
      chk_out("negsat", 32'h20000, 1'b1);
      handshake("negsat");

      // Clamp then recover
      push_n(16'd32767, 5); push(16'h8000); push(16'h8000); push(16'd0);
      chk_out("recover", 32'd65535, 1'b1);
      handshake("recover");

      // Backpressure: dropped samples during HOLD
      out_ready = 1'b0;
      push_n(16'd2, 8);
      chk_out("bp", 32'd16, 1'b0);
      in_valid = 1'b1; in_data = 16'd9;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_data", {14'd0, out_data}, 32'd16);
      end
      handshake("bp");
      in_valid = 1'b0;
      push_n(16'd3, 8);
      chk_out("bp_next", 32'd24, 1'b0);
      handshake("bp_next");

      // Reset mid-block
      push_n(16'd1000, 3);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_ready", {31'd0, in_ready}, 32'd0);
      chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
      chk("rstmid_data", {14'd0, out_data}, 32'd0);
      chk("rstmid_ovf", {31'd0, out_ovf}, 32'd0);
      rst = 1'b0;
      step();
      push_n(16'd1, 8);
      chk_out("rstmid_after", 32'd8, 1'b0);
      handshake("rstmid_after");

      // Reset during HOLD
      out_ready = 1'b0;
      push_n(16'd5, 8);
      chk_out("rsthold_pre", 32'd40, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("rsthold_valid", {31'd0, out_valid}, 32'd0);
      chk("rsthold_data", {14'd0, out_data}, 32'd0);
      chk("rsthold_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      push_n(16'd1, 8);
      chk_out("rsthold_after", 32'd8, 1'b0);
      handshake("rsthold_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/accfxp_blk_obf.md
# accfxp_blk_obf

Block accumulator that sits directly downstream of the locked fixed-point add/sub stage. It consumes the stage's signed `width`-bit result stream, sums `count` consecutive valid samples into a wider signed accumulator, and presents each block sum on a valid/ready output register. One locking key bit selects between correct saturating arithmetic and an incorrect wrapping mode. An overflow flag is reported in both modes.

## Interface
- `width`, 16: input sample width, signed two's complement; matches the upstream stage.
- `acc_width`, 24: accumulator and output width, signed; must be ≥ `width`.
- `count`, 8: samples per block; must be ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_data` holds a sample this cycle.
- `in_data`  in  `width`  signed sample; the upstream stage's `q`.
- `in_ready`  out  1  block accepts a sample this cycle.
- `out_valid`  out  1  block sum held in `out_data`.
- `out_data`  out  `acc_width`  signed block sum.
- `out_ovf`  out  1  a range overflow occurred during this block.
- `out_ready`  in  1  consumer takes `out_data` this cycle.
- `working_locking_key`  in  [0:0]  locking key; 1 is the correct key.

## Operation
- **States.**
  - ACCUM: accepting samples.
  - HOLD: result pending.
  - Reset state is ACCUM.
- **in_ready.** Equals (state == ACCUM) & ~`rst`. It has no combinational dependence on `out_ready`.
- **Accept.** A sample is accepted when `in_valid` & `in_ready`. Samples with `in_valid` high while `in_ready` is low are dropped.
- **Per-accept arithmetic.**
  - Form exact = acc + sign-extended `in_data`, computed at `acc_width`+1 bits.
  - An overflow occurs when exact is above 2^(acc_width-1)-1 or below -2^(acc_width-1).
  - Key = 1: the result clamps to the nearest bound.
  - Key = 0: the result is exact truncated to `acc_width` bits (wrap).
  - In both key settings an overflow sets the sticky block flag `ovf_r`.
  - Clamping is applied at every step. Later samples continue from the clamped value.
- **Sample counter.** `cnt` runs 0..`count`-1 and increments on each accept.
- **Accept with `cnt` < `count`-1.** The accumulator takes the new result.
- **Accept with `cnt` == `count`-1 (last sample).**
  - `out_data` ← new result.
  - `out_ovf` ← `ovf_r` | overflow on this step.
  - `out_valid` ← 1.
  - acc ← 0, `cnt` ← 0, `ovf_r` ← 0.
  - State → HOLD.
- **HOLD.**
  - `out_data` and `out_ovf` stay stable.
  - When `out_ready` = 1: `out_valid` ← 0 and state → ACCUM at that edge.
  - `out_data` and `out_ovf` keep their last values after the handshake.
- **count = 1.** Every accepted sample forms a complete block.
- **Key change mid-block.** The key is sampled on each accept. No other state depends on it.

## Timing
- **Reset values.** While `rst` is high, asynchronously:
  - `out_valid` = 0, `out_data` = 0, `out_ovf` = 0, `in_ready` = 0.
  - acc = 0, `cnt` = 0, `ovf_r` = 0, state = ACCUM.
- **After reset.** `in_ready` = 1 in the first cycle after `rst` deasserts.
- **Latency.** `out_valid` rises on the edge that accepts the last sample of a block, i.e. 1 cycle after that sample is presented.
- **Throughput.** Each block takes `count` accept cycles plus ≥ 1 HOLD cycle. With `out_ready` tied high, a block repeats every `count`+1 cycles.
- **Reset mid-block or in HOLD.** All partial state is discarded. The pending output is lost and `out_valid` drops immediately.
- **Simultaneous events.** `out_ready` and `in_valid` high in the same HOLD cycle: only the output handshake happens. The sample is not accepted.

## Test plan
Setup for all scenarios: `width`=16, `acc_width`=18, `count`=8.
- **Basic sum.** Key=1, `out_ready`=1. Feed 100, −30, 7, 0, 0, 0, 0, 0 back to back → `out_data`=77, `out_ovf`=0, `out_valid` high for exactly 1 cycle on the edge after the 8th accept; `in_ready` low that cycle.
- **Positive saturation.** Key=1. Feed 8 × 32767 → `out_data`=131071, `out_ovf`=1. Then feed 8 × 1 → `out_data`=8, `out_ovf`=0 (flag clears between blocks).
- **Wrong key.** Key=0. Feed 8 × 32767 → `out_data`=−8 (wrapped 262136), `out_ovf`=1. Feed 8 × −32768 with key=1 → `out_data`=−131072, `out_ovf`=1.
- **Clamp then recover.** Key=1. Feed 5 × 32767 then −32768, −32768, 0 → step-wise clamp gives 131071−65536 = 65535, `out_ovf`=1.
- **Backpressure.**
  - Complete a block with `out_ready`=0 held for 5 cycles while `in_valid`=1 with data 9 → `in_ready`=0 and `out_data` stable throughout; the 9s are dropped.
  - After `out_ready`=1 for 1 cycle → next cycle `in_ready`=1, and the next block sums only newly accepted samples.
- **Reset mid-block.**
  - Accept 3 samples of 1000, then pulse `rst` asynchronously (between edges) → outputs and `in_ready` go 0 immediately.
  - After release, 8 × 1 → `out_data`=8.
  - Repeat with `rst` asserted during HOLD → `out_valid` drops immediately.
